// File: rtl/spike_aer_encoder.sv
// Serialises a parallel spike vector into an address-event stream {neuron id, timestamp}.
// Each neuron has a one-deep pending slot in front of a shared event FIFO.
module spike_aer_encoder #(
    parameter int N_NEURONS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 8,
    localparam int AW = $clog2(N_NEURONS),
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int LW = PW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [AW-1:0]        ev_addr,
    output logic [TS_WIDTH-1:0]  ev_ts,
    output logic [LW-1:0]        fifo_level,
    output logic [7:0]           drop_count,
    output logic                 overflow
);

    // Output handshake: an event transfers on any rising edge where ev_valid and
    // ev_ready are both 1; ev_valid depends only on stored state, never on ev_ready,
    // and the head event stays stable until it transfers.

    logic [TS_WIDTH-1:0]  r_ts;
    logic [N_NEURONS-1:0] r_pending;
    logic [TS_WIDTH-1:0]  r_ts_pend [N_NEURONS];
    logic [AW-1:0]        r_mem_addr [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]  r_mem_ts [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic [7:0]           r_drop_count;
    logic                 r_overflow;

    logic                 w_pop;
    logic                 w_push;
    logic                 w_grant_any;
    logic [AW-1:0]        w_grant_idx;
    logic [N_NEURONS-1:0] w_push_mask;
    logic [N_NEURONS-1:0] w_spike;
    logic [N_NEURONS-1:0] w_drop_bits;
    logic [N_NEURONS-1:0] w_capture;
    logic [AW:0]          w_drop_cnt;
    logic [8:0]           w_drop_sum;
    logic [7:0]           w_drop_next;

    assign ev_valid   = (r_level != '0);
    assign ev_addr    = ev_valid ? r_mem_addr[r_rd_ptr] : '0;
    assign ev_ts      = ev_valid ? r_mem_ts[r_rd_ptr] : '0;
    assign fifo_level = r_level;
    assign drop_count = r_drop_count;
    assign overflow   = r_overflow;

    assign w_pop = ev_valid & ev_ready;

    // Scan from the top so the lowest set index wins.
    always_comb begin
        w_grant_idx = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (r_pending[i]) w_grant_idx = AW'(i);
        end
    end

    assign w_grant_any = |r_pending;
    assign w_push      = w_grant_any && ((r_level < LW'(FIFO_DEPTH)) || w_pop);
    assign w_push_mask = w_push ? (N_NEURONS'(1) << w_grant_idx) : '0;

    // A spike on a neuron whose slot is still occupied (and not leaving this
    // cycle) is merged into the older event; everything else is captured.
    assign w_spike     = en ? spike_in : '0;
    assign w_drop_bits = w_spike & r_pending & ~w_push_mask;
    assign w_capture   = w_spike & ~w_drop_bits;

    always_comb begin
        w_drop_cnt = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            w_drop_cnt = w_drop_cnt + {{AW{1'b0}}, w_drop_bits[i]};
        end
    end

    assign w_drop_sum  = {1'b0, r_drop_count} + 9'(w_drop_cnt);
    assign w_drop_next = (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts         <= '0;
            r_pending    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) r_ts_pend[i] <= '0;
        end else begin
            if (en) r_ts <= r_ts + TS_WIDTH'(1);
            r_pending <= (r_pending & ~w_push_mask) | w_capture;
            for (int i = 0; i < N_NEURONS; i++) begin
                if (w_capture[i]) r_ts_pend[i] <= r_ts;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (|w_drop_bits) begin
                r_drop_count <= w_drop_next;
                r_overflow   <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= w_grant_idx;
            r_mem_ts[r_wr_ptr]   <= r_ts_pend[w_grant_idx];
        end
    end

endmodule
